// File: rtl/ex_pkg.sv
// Shared types for the pipelined execute stage: opcodes, branch conditions and
// the multiplier FSM states.
package ex_pkg;

  typedef enum logic [3:0] {
    OpAdd  = 4'd0,
    OpSub  = 4'd1,
    OpXor  = 4'd2,
    OpAndn = 4'd3,
    OpSll  = 4'd4,
    OpSrl  = 4'd5,
    OpRol  = 4'd6,
    OpRor  = 4'd7,
    OpSeq  = 4'd8,
    OpSlt  = 4'd9,
    OpSle  = 4'd10,
    OpSco  = 4'd11,
    OpLbi  = 4'd12,
    OpSlbi = 4'd13,
    OpMul  = 4'd14
  } op_t;

  localparam logic [3:0] OpIllegal = 4'd15;

  typedef enum logic [1:0] {
    BrEqz = 2'b00,
    BrNez = 2'b01,
    BrLtz = 2'b10,
    BrGez = 2'b11
  } br_cond_t;

  typedef enum logic [1:0] {
    MulIdle = 2'd0,
    MulBusy = 2'd1,
    MulDone = 2'd2
  } mul_state_t;

endpackage

// File: rtl/execute_stage_pipe_if.sv
// Decode-side and memory-side handshake bundle of the execute stage.
interface execute_stage_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic [WIDTH-1:0] imm;
  logic             alu_src;
  logic [1:0]       br_cond;
  logic             is_branch;
  logic [WIDTH-1:0] pc_plus2;
  logic [WIDTH-1:0] pc_target;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             br_taken;
  logic [WIDTH-1:0] next_pc;
  logic             err;

  modport master (
    output flush, in_valid, op, rs_data, rt_data, imm, alu_src, br_cond, is_branch,
           pc_plus2, pc_target, out_ready,
    input  in_ready, out_valid, result, br_taken, next_pc, err
  );

  modport slave (
    input  flush, in_valid, op, rs_data, rt_data, imm, alu_src, br_cond, is_branch,
           pc_plus2, pc_target, out_ready,
    output in_ready, out_valid, result, br_taken, next_pc, err
  );
endinterface

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low WIDTH bits kept.
module ex_mul_iter
  import ex_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ack,
  output logic             idle,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CntW = $clog2(WIDTH);

  mul_state_t       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MulIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    unique case (state_q)
      MulIdle: begin
        if (start) begin
          state_d  = MulBusy;
          cnt_d    = CntW'(WIDTH - 1);
          acc_d    = '0;
          mcand_d  = a;
          mplier_d = b;
        end
      end
      MulBusy: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == '0) begin
          state_d = MulDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MulDone: begin
        if (ack) state_d = MulIdle;
      end
      default: state_d = MulIdle;
    endcase
    // A flush discards the product wherever the FSM is.
    if (abort) state_d = MulIdle;
  end

  assign idle    = (state_q == MulIdle);
  assign done    = (state_q == MulDone);
  assign product = acc_q;

endmodule

// File: rtl/execute_stage_pipe.sv
// Pipelined execute stage: combinational ALU and branch resolution feeding a
// registered EX/MEM slot, with an optional iterative multiplier.
module execute_stage_pipe
  import ex_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  execute_stage_pipe_if.slave bus
);

  localparam int unsigned ShW = $clog2(WIDTH);

  op_t              op;
  logic [WIDTH-1:0] a, b, alu_res, npc_now, mul_prod;
  logic             is_mul, illegal, cond_ok, br_now;
  logic             slot_free, accept, mul_idle, mul_done, mul_write;

  logic             out_valid_q, br_q, err_q, mul_br_q;
  logic [WIDTH-1:0] result_q, npc_q, mul_npc_q;

  assign op      = op_t'(bus.op);
  assign a       = bus.rs_data;
  assign b       = bus.alu_src ? bus.rt_data : bus.imm;
  assign is_mul  = MUL_EN && (op == OpMul);
  assign illegal = (bus.op == OpIllegal) || (!MUL_EN && (op == OpMul));

  always_comb begin : p_alu
    logic [ShW-1:0]     sh;
    logic [2*WIDTH-1:0] wide;
    sh      = b[ShW-1:0];
    wide    = '0;
    alu_res = '0;
    case (op)
      OpAdd:  alu_res = a + b;
      OpSub:  alu_res = b - a;
      OpXor:  alu_res = a ^ b;
      OpAndn: alu_res = a & ~b;
      OpSll:  alu_res = a << sh;
      OpSrl:  alu_res = a >> sh;
      OpRol: begin
        wide    = {a, a} << sh;
        alu_res = wide[2*WIDTH-1:WIDTH];
      end
      OpRor: begin
        wide    = {a, a} >> sh;
        alu_res = wide[WIDTH-1:0];
      end
      OpSeq:  alu_res = WIDTH'(a == b);
      OpSlt:  alu_res = WIDTH'($signed(a) < $signed(b));
      OpSle:  alu_res = WIDTH'($signed(a) <= $signed(b));
      OpSco: begin
        wide    = {{WIDTH{1'b0}}, a} + {{WIDTH{1'b0}}, b};
        alu_res = WIDTH'(wide[WIDTH]);
      end
      OpLbi:  alu_res = b;
      OpSlbi: alu_res = (a << 8) | {{(WIDTH-8){1'b0}}, b[7:0]};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    cond_ok = 1'b0;
    unique case (br_cond_t'(bus.br_cond))
      BrEqz: cond_ok = (a == '0);
      BrNez: cond_ok = (a != '0);
      BrLtz: cond_ok = a[WIDTH-1];
      BrGez: cond_ok = !a[WIDTH-1];
      default: cond_ok = 1'b0;
    endcase
    br_now  = bus.is_branch && cond_ok && !illegal;
    npc_now = br_now ? bus.pc_target : bus.pc_plus2;
  end

  assign slot_free    = !out_valid_q || bus.out_ready;
  assign bus.in_ready = !rst && !bus.flush && mul_idle && slot_free;
  assign accept       = bus.in_valid && bus.in_ready;
  assign mul_write    = mul_done && slot_free && !bus.flush;

  if (MUL_EN) begin : g_mul
    ex_mul_iter #(
      .WIDTH(WIDTH)
    ) u_mul (
      .clk    (clk),
      .rst    (rst),
      .abort  (bus.flush),
      .start  (accept && is_mul),
      .a      (a),
      .b      (b),
      .ack    (mul_write),
      .idle   (mul_idle),
      .done   (mul_done),
      .product(mul_prod)
    );
  end else begin : g_no_mul
    assign mul_idle = 1'b1;
    assign mul_done = 1'b0;
    assign mul_prod = '0;
  end

  // Branch outcome of a multiply travels with it until the product lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_br_q  <= 1'b0;
      mul_npc_q <= '0;
    end else if (accept && is_mul) begin
      mul_br_q  <= br_now;
      mul_npc_q <= npc_now;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      br_q        <= 1'b0;
      npc_q       <= '0;
      err_q       <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (accept && !is_mul) begin
      out_valid_q <= 1'b1;
      result_q    <= illegal ? '0 : alu_res;
      br_q        <= br_now;
      npc_q       <= npc_now;
      err_q       <= illegal;
    end else if (mul_write) begin
      out_valid_q <= 1'b1;
      result_q    <= mul_prod;
      br_q        <= mul_br_q;
      npc_q       <= mul_npc_q;
      err_q       <= 1'b0;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.br_taken  = br_q;
  assign bus.next_pc   = npc_q;
  assign bus.err       = err_q;

endmodule

// File: doc/execute_stage_pipe.md
# execute_stage_pipe

Parametrised, pipelined successor to the single-cycle execute stage: a WIDTH-bit execute unit with a registered EX/MEM output slot, valid/ready handshakes on both sides, registered branch resolution and an iterative multi-cycle multiplier. It sits between the decode/register-read stage and the memory stage. It accepts one instruction per cycle for single-cycle ops and back-pressures decode while a multiply is in flight or memory stalls.

## Interface
Parameters:
- WIDTH, 16: datapath width (≥ 8, even).
- MUL_EN, 1: 1 instantiates the iterative multiplier; 0 makes OP_MUL illegal.

Ports:
- clk  in  1  clock; everything is registered on the rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  kills the accepted and in-flight instruction this cycle (branch mispredict upstream).
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  the stage accepts the instruction this cycle.
- op  in  4  operation code, ex_pkg encoding.
- rs_data, rt_data, imm  in  WIDTH each  operands.
- alu_src  in  1  1 selects B = rt_data, 0 selects B = imm.
- br_cond  in  2  00 EQZ, 01 NEZ, 10 LTZ, 11 GEZ; tested on rs_data.
- is_branch  in  1  the instruction is a conditional branch.
- pc_plus2, pc_target  in  WIDTH each  fall-through PC and branch-target PC.
- out_valid  out  1  the output slot holds a result.
- out_ready  in  1  memory consumes the slot.
- result  out  WIDTH  registered result.
- br_taken  out  1  registered branch decision.
- next_pc  out  WIDTH  pc_target when br_taken, else pc_plus2.
- err  out  1  illegal op in the slot; valid with out_valid.

## Operation
- A = rs_data. B = alu_src ? rt_data : imm.
- Single-cycle ops:
  - ADD: A+B.
  - SUB: B−A.
  - XOR.
  - ANDN: A & ~B.
  - SLL, SRL, ROL, ROR: A by B[log2(WIDTH)-1:0].
  - SEQ, SLT, SLE: signed compares, 1/0.
  - SCO: carry-out of A+B.
  - LBI: B.
  - SLBI: (A << 8) | B[7:0].
  - All results are truncated to WIDTH.
- MUL: low WIDTH bits of A×B (unsigned). Computed by a shift-add FSM, one bit per cycle.
- Multiplier FSM states: IDLE → BUSY (WIDTH cycles, counter WIDTH-1 down to 0) → DONE (writes the slot when the slot is free or being drained) → IDLE.
- Branch: br_taken = is_branch & cond(rs_data). Non-branches give br_taken = 0 and next_pc = pc_plus2.
- An unused op code, or MUL with MUL_EN = 0, gives a slot with err = 1, result = 0 and br_taken = 0. It does not stall.
- Accept rule: in_ready = !flush & (FSM == IDLE) & (!out_valid | out_ready).
- flush: clears out_valid. The FSM returns to IDLE and its result is discarded. in_valid is ignored in that cycle.

## Timing
- Reset values: out_valid 0, result 0, br_taken 0, next_pc 0, err 0, FSM IDLE, counter 0. With rst held, in_ready = 0.
- Single-cycle op accepted at edge N: out_valid = 1 after edge N, carrying the result. Back-to-back issue gives throughput 1/cycle while out_ready = 1.
- MUL accepted at edge N: in_ready = 0 for WIDTH+1 cycles. The slot is written at edge N+WIDTH+1 if the slot is free or being drained. Otherwise DONE holds until it is.
- Slot hold: while out_valid & !out_ready, all outputs stay stable and in_ready = 0.
- Drain and refill in the same cycle (out_valid & out_ready & accept) replaces the slot with no bubble.
- Simultaneous flush and out_ready: the current slot is consumed and nothing new is written.
- rst overrides flush and the handshakes. rst mid-multiply aborts to IDLE.
- Wrap-around: ADD/SUB overflow is silently truncated. A shift amount ≥ WIDTH is masked to its low log2(WIDTH) bits.

## Structure
- Package ex_pkg holds:
  - op_t, the 4-bit enum (ADD=0, SUB=1, XOR=2, ANDN=3, SLL=4, SRL=5, ROL=6, ROR=7, SEQ=8, SLT=9, SLE=10, SCO=11, LBI=12, SLBI=13, MUL=14; 15 is illegal).
  - br_cond_t.
  - mul_state_t (IDLE, BUSY, DONE).
- One sub-module, ex_mul_iter, contains the multiplier FSM, counter and accumulator, with a start/done handshake. It is generated only when MUL_EN = 1.
- The combinational ALU, the branch logic and the output slot live in the top module.

## Test plan
- Reset, then ADD with A = 0x0003, imm = 0x0004, alu_src = 0 → next cycle out_valid = 1, result = 0x0007, next_pc = pc_plus2.
- SLBI with A = 0x00AB, imm = 0x00CD; then SUB with A = 5, B = 3 back-to-back, out_ready = 1 → results 0xABCD then 0xFFFE on consecutive cycles.
- MUL with A = 0x0012, B = 0x0034 (WIDTH = 16) → in_ready low for 17 cycles, then result = 0x03A8. Repeat with out_ready = 0 for 3 extra cycles → result held stable and in_ready = 0 until the drain.
- Branch LTZ with rs_data = 0x8000, pc_target = 0x0040 → br_taken = 1, next_pc = 0x0040. The same branch with GEZ → br_taken = 0, next_pc = pc_plus2.
- Assert flush 5 cycles into a MUL → no result is produced, in_ready = 1 the cycle after flush, and the next ADD completes normally. Repeat the MUL with rst asserted mid-multiply → same outcome, all outputs zero.
- Op = 15, and MUL under MUL_EN = 0 → err = 1, result = 0, no stall. WIDTH = 32 build: ROL of 0x80000001 by 1 → 0x00000003.
